// File: rtl/lb_cfg_master.sv
// Localbus configuration master: turns host rule-table read/write commands into
// ALE / chip-select / ack-handshake bus cycles, with a bounded wait on each ack edge.
module lb_cfg_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        localbus_cs_n,
    output logic        localbus_rd_wr,
    output logic [31:0] localbus_data,
    output logic        localbus_ale,
    input  logic        localbus_ack_n,
    input  logic [31:0] localbus_data_out,
    output logic [15:0] timeout_cnt
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        SETUP   = 3'd2,
        ACCESS  = 3'd3,
        RELEASE = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        cs_n_q, cs_n_d;
    logic        ale_q, ale_d;
    logic [31:0] data_q, data_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;
    logic [15:0] tcnt_q, tcnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ADDR;
                    wdata_d = cmd_wdata;
                    rd_d    = cmd_rd_wr;
                    data_d  = cmd_addr;
                end
            end
            ADDR: begin
                state_d = SETUP;
                data_d  = rd_q ? 32'd0 : wdata_q;
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = 16'd0;
            end
            ACCESS: begin
                if (!localbus_ack_n) begin
                    state_d = RELEASE;
                    rdata_d = rd_q ? localbus_data_out : 32'd0;
                    to_d    = 1'b0;
                    wait_d  = 16'd0;
                    data_d  = 32'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RELEASE;
                    rdata_d = 32'd0;
                    to_d    = 1'b1;
                    tcnt_d  = sat_inc(tcnt_q);
                    wait_d  = 16'd0;
                    data_d  = 32'd0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RELEASE: begin
                if (localbus_ack_n) begin
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    // a slave stuck on ack is counted only if the access itself did not time out
                    state_d = RESP;
                    rdata_d = 32'd0;
                    to_d    = 1'b1;
                    if (!to_q) tcnt_d = sat_inc(tcnt_q);
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // bus/handshake outputs are registered from the next state so they line up with it
        ale_d       = (state_d == ADDR);
        cs_n_d      = (state_d != ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= 16'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            ale_q       <= 1'b0;
            data_q      <= 32'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            to_q        <= 1'b0;
            tcnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cs_n_q      <= cs_n_d;
            ale_q       <= ale_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            to_q        <= to_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_timeout    = to_q;
    assign localbus_cs_n  = cs_n_q;
    assign localbus_rd_wr = rd_q;
    assign localbus_data  = data_q;
    assign localbus_ale   = ale_q;
    assign timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_lb_cfg_master.sv
// Directed bench for lb_cfg_master: a table of transactions against a small slave
// model, plus hand sequences for back-to-back issue and reset in mid-access.
module tb_lb_cfg_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rd_wr = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        localbus_cs_n;
    logic        localbus_rd_wr;
    logic [31:0] localbus_data;
    logic        localbus_ale;
    logic        localbus_ack_n = 1'b1;
    logic [31:0] localbus_data_out = 32'd0;
    logic [15:0] timeout_cnt;

    lb_cfg_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .localbus_cs_n(localbus_cs_n), .localbus_rd_wr(localbus_rd_wr),
        .localbus_data(localbus_data), .localbus_ale(localbus_ale),
        .localbus_ack_n(localbus_ack_n), .localbus_data_out(localbus_data_out),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;     // slave read data presented during the transaction
        int          ack_dly;   // access cycle index at which ack goes low (>= TO: never)
        int          rel_hold;  // cycles ack stays low after cs_n rises
        int          rdy_dly;   // cycles rsp_ready is held low once rsp_valid is seen
        bit          b2b;       // present the next command while waiting in RESP
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_cs;
        int          exp_lat;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    int n_vec = 0;
    int n_bad = 0;
    int exp_tcnt = 0;
    int hs_cyc = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input bit has_next, input vec_t nv, input bit chk_gap);
        int k, cs_cnt, rel_cnt, ale_cnt, lat, guard, ale_cyc;
        bit bus_ok, hold_ok;
        logic [31:0] snap_rdata;
        logic snap_to;
        k = 0; cs_cnt = 0; rel_cnt = 0; ale_cnt = 0; lat = -1; guard = 0; ale_cyc = -1;
        bus_ok = 1; hold_ok = 1;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_rd_wr = v.rd; cmd_addr = v.addr; cmd_wdata = v.wdata;
        localbus_data_out = v.sdata;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({v.name, " accept"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);

        while (k < 100) begin
            @(negedge clk);
            k++;
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (localbus_ale) begin
                ale_cnt++;
                if (ale_cyc < 0) ale_cyc = cyc;
                if (localbus_data !== v.addr || localbus_rd_wr !== v.rd || localbus_cs_n !== 1'b1)
                    bus_ok = 0;
            end
            if (!localbus_cs_n) begin
                cs_cnt++;
                if (localbus_data !== (v.rd ? 32'd0 : v.wdata) || localbus_rd_wr !== v.rd)
                    bus_ok = 0;
                localbus_ack_n = (cs_cnt - 1 >= v.ack_dly) ? 1'b0 : 1'b1;
            end else if (cs_cnt > 0) begin
                rel_cnt++;
                if (localbus_data !== 32'd0) bus_ok = 0;
                if (rel_cnt > v.rel_hold) localbus_ack_n = 1'b1;
            end
        end
        localbus_ack_n = 1'b1;

        chk({v.name, " ale_cycles"}, 32'(ale_cnt), 32'd1);
        chk({v.name, " cs_low_cycles"}, 32'(cs_cnt), 32'(v.exp_cs));
        chk({v.name, " bus_fields"}, 32'(bus_ok), 32'd1);
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        if (v.exp_to) exp_tcnt++;
        chk({v.name, " timeout_cnt"}, 32'(timeout_cnt), 32'(exp_tcnt));
        if (chk_gap) chk({v.name, " handshake_to_ale"}, 32'(ale_cyc - hs_cyc), 32'd2);

        snap_rdata = rsp_rdata;
        snap_to = rsp_timeout;
        if (has_next) begin
            cmd_valid = 1'b1; cmd_rd_wr = nv.rd; cmd_addr = nv.addr; cmd_wdata = nv.wdata;
        end
        for (int j = 0; j < v.rdy_dly; j++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== snap_rdata || rsp_timeout !== snap_to ||
                cmd_ready !== 1'b0 || localbus_ale !== 1'b0)
                hold_ok = 0;
        end
        if (v.rdy_dly > 0) chk({v.name, " resp_hold"}, 32'(hold_ok), 32'd1);
        rsp_ready = 1'b1;
        hs_cyc = cyc;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t nil;
        bit quiet;
        int guard;
        vecs[0] = '{"wr_eng2", 1'b0, 32'h0002_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 0, 0, 1'b0,
                    32'h0, 1'b0, 3, 7};
        vecs[1] = '{"rd_eng1", 1'b1, 32'h0001_0004, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b0,
                    32'h1234_5678, 1'b0, 1, 5};
        vecs[2] = '{"rd_timeout", 1'b1, 32'h0003_0020, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 99, 0, 0, 1'b0,
                    32'h0, 1'b1, TO, 12};
        vecs[3] = '{"b2b_first", 1'b0, 32'h0000_0100, 32'h1111_2222, 32'h0, 1, 1, 4, 1'b1,
                    32'h0, 1'b0, 2, 7};
        vecs[4] = '{"b2b_second", 1'b1, 32'h0001_0200, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1'b0,
                    32'hCAFE_F00D, 1'b0, 1, 5};
        vecs[5] = '{"stuck_ack", 1'b1, 32'h0002_0300, 32'h0, 32'h55AA_55AA, 0, 20, 0, 1'b0,
                    32'h0, 1'b1, 1, 12};
        vecs[6] = '{"ack_last_cycle", 1'b0, 32'h0000_0004, 32'h0F0F_0F0F, 32'h0, TO - 1, 0, 0, 1'b0,
                    32'h0, 1'b0, TO, 12};
        nil = vecs[0];

        repeat (3) @(negedge clk);
        chk("reset cs_n", 32'(localbus_cs_n), 32'd1);
        chk("reset ale", 32'(localbus_ale), 32'd0);
        chk("reset rd_wr", 32'(localbus_rd_wr), 32'd0);
        chk("reset data", localbus_data, 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("reset timeout_cnt", 32'(timeout_cnt), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].b2b && i + 1 < NV)
                run_txn(vecs[i], 1'b1, vecs[i+1], 1'b0);
            else
                run_txn(vecs[i], 1'b0, nil, (i > 0) && vecs[i-1].b2b);
        end

        // reset while the bus is in the access phase
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rd_wr = 1'b0; cmd_addr = 32'h0003_0040; cmd_wdata = 32'h7777_8888;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (localbus_cs_n && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_reset reached_access", 32'(localbus_cs_n), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset cs_n_async", 32'(localbus_cs_n), 32'd1);
        chk("mid_reset cmd_ready", 32'(cmd_ready), 32'd1);
        exp_tcnt = 0;
        chk("mid_reset timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet = 1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (rsp_valid || !localbus_cs_n) quiet = 0;
        end
        chk("mid_reset no_response", 32'(quiet), 32'd1);
        run_txn(vecs[1], 1'b0, nil, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
